// File: rtl/serial_addsub_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
// The requester drives start/sub/a/b; the serial unit returns status and result.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell consumes one operand bit
// per clock, LSB first, and publishes sum/carry/overflow after WIDTH cycles.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_addsub_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-2:0] r_q, r_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [1:0]       fa;
  logic [WIDTH-1:0] r_sh;

  // Two half adders plus a carry OR; returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    logic h1_s, h1_c, h2_s, h2_c;
    h1_s = x ^ y;
    h1_c = x & y;
    h2_s = h1_s ^ ci;
    h2_c = h1_s & ci;
    return {h1_c | h2_c, h2_s};
  endfunction

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    fa   = full_add(a_q[0], b_q[0], carry_q);
    // R keeps only the upper WIDTH-1 bits; the final bit completes it on the last edge.
    r_sh = {fa[0], r_q};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        r_d     = r_sh[WIDTH-1:1];
        carry_d = fa[1];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          // carry_q here is the carry into the MSB, so overflow is its XOR with carry out.
          sum_d   = r_sh;
          cout_d  = fa[1];
          ovf_d   = carry_q ^ fa[1];
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub at WIDTH 8, 2 and 32, with an arithmetic
// reference for the exhaustive 2-bit and random 32-bit operations.
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(8))  if8  ();
  serial_addsub_if #(.WIDTH(2))  if2  ();
  serial_addsub_if #(.WIDTH(32)) if32 ();

  serial_addsub #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_addsub #(.WIDTH(2))  u_dut2  (.clk(clk), .rst_n(rst_n), .bus(if2));
  serial_addsub #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic s,
                       input logic [31:0] a, input logic [31:0] b);
    case (w)
      2:       begin if2.start = st;  if2.sub = s;  if2.a = a[1:0];  if2.b = b[1:0];  end
      8:       begin if8.start = st;  if8.sub = s;  if8.a = a[7:0];  if8.b = b[7:0];  end
      default: begin if32.start = st; if32.sub = s; if32.a = a;      if32.b = b;      end
    endcase
  endtask

  function automatic logic cur_done(input int w);
    return (w == 2) ? if2.done : (w == 8) ? if8.done : if32.done;
  endfunction

  function automatic logic cur_busy(input int w);
    return (w == 2) ? if2.busy : (w == 8) ? if8.busy : if32.busy;
  endfunction

  function automatic logic [31:0] cur_sum(input int w);
    return (w == 2) ? 32'(if2.sum) : (w == 8) ? 32'(if8.sum) : if32.sum;
  endfunction

  function automatic logic cur_cout(input int w);
    return (w == 2) ? if2.cout : (w == 8) ? if8.cout : if32.cout;
  endfunction

  function automatic logic cur_ovf(input int w);
    return (w == 2) ? if2.ovf : (w == 8) ? if8.ovf : if32.ovf;
  endfunction

  // Reference: wide integer sum of a + (b or ~b) + sub, overflow from operand/result signs.
  task automatic model(input int w, input logic s, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] rs, output logic rc, output logic ro);
    logic [63:0] mask, am, bm, full;
    mask = (64'd1 << w) - 64'd1;
    am   = {32'd0, a} & mask;
    bm   = (s ? ~{32'd0, b} : {32'd0, b}) & mask;
    full = am + bm + {63'd0, s};
    rs   = 32'(full & mask);
    rc   = full[w];
    ro   = (am[w-1] == bm[w-1]) && (full[w-1] != am[w-1]);
  endtask

  task automatic run_op(input int w, input logic s, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rs, output logic rc, output logic ro,
                        output int lat, output int bc, output logic done_after);
    @(negedge clk);
    drive(w, 1'b1, s, a, b);
    @(posedge clk); #1;
    drive(w, 1'b0, ~s, 32'hDEAD_BEEF, 32'h1234_5678);
    lat = 0;
    bc  = 0;
    while (!cur_done(w) && lat < 200) begin
      if (cur_busy(w)) bc++;
      @(posedge clk); #1;
      lat++;
    end
    rs = cur_sum(w);
    rc = cur_cout(w);
    ro = cur_ovf(w);
    @(posedge clk); #1;
    done_after = cur_done(w);
  endtask

  task automatic op_chk(input string tag, input int w, input logic s,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] es, input logic ec, input logic eo);
    logic [31:0] rs;
    logic rc, ro, da;
    int lat, bc;
    run_op(w, s, a, b, rs, rc, ro, lat, bc, da);
    chk({tag, ".sum"},  64'(rs), 64'(es));
    chk({tag, ".cout"}, 64'(rc), 64'(ec));
    chk({tag, ".ovf"},  64'(ro), 64'(eo));
    chk({tag, ".lat"},  64'(lat), 64'(w));
    chk({tag, ".busy"}, 64'(bc), 64'(w));
    chk({tag, ".pulse"}, 64'(da), 64'd0);
  endtask

  initial begin
    logic [31:0] es, ra, rb;
    logic ec, eo, sb;
    int ndone;
    logic [7:0] cap;

    drive(2, 1'b0, 1'b0, 0, 0);
    drive(8, 1'b0, 1'b0, 0, 0);
    drive(32, 1'b0, 1'b0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", 64'(if8.busy), 64'd0);
    chk("rst.done", 64'(if8.done), 64'd0);
    chk("rst.sum",  64'({if8.sum, if8.cout, if8.ovf}), 64'd0);
    chk("rst.sum32", 64'(if32.sum), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Hand-computed 8-bit vectors
    op_chk("add5A33", 8, 1'b0, 32'h5A, 32'h33, 32'h8D, 1'b0, 1'b1);
    op_chk("addFF01", 8, 1'b0, 32'hFF, 32'h01, 32'h00, 1'b1, 1'b0);
    op_chk("add7F7F", 8, 1'b0, 32'h7F, 32'h7F, 32'hFE, 1'b0, 1'b1);
    op_chk("sub1020", 8, 1'b1, 32'h10, 32'h20, 32'hF0, 1'b0, 1'b0);
    op_chk("sub8001", 8, 1'b1, 32'h80, 32'h01, 32'h7F, 1'b1, 1'b1);

    // start held through RUN and DONE must not queue a second operation
    @(negedge clk);
    drive(8, 1'b1, 1'b0, 32'h01, 32'h01);
    @(posedge clk); #1;
    if8.a = 8'hFF;
    ndone = 0;
    cap = 8'h00;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (if8.done) begin
        ndone++;
        cap = if8.sum;
      end
    end
    if8.start = 1'b0;
    @(posedge clk); #1;
    chk("ign.ndone", 64'(ndone), 64'd1);
    chk("ign.sum",   64'(cap), 64'h02);
    chk("ign.idle",  64'({if8.busy, if8.done}), 64'd0);
    op_chk("add2211", 8, 1'b0, 32'h22, 32'h11, 32'h33, 1'b0, 1'b0);

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    drive(8, 1'b1, 1'b0, 32'h0F, 32'h01);
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.busy", 64'(if8.busy), 64'd0);
    chk("arst.done", 64'(if8.done), 64'd0);
    chk("arst.sum",  64'(if8.sum), 64'd0);
    chk("arst.flags", 64'({if8.cout, if8.ovf}), 64'd0);
    ndone = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (if8.done || if8.busy) ndone++;
    end
    chk("arst.nodone", 64'(ndone), 64'd0);
    op_chk("add0304", 8, 1'b0, 32'h03, 32'h04, 32'h07, 1'b0, 1'b0);

    // 32-bit boundary vectors
    op_chk("w32.wrap",  32, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0,         1'b1, 1'b0);
    op_chk("w32.povf",  32, 1'b0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1);
    op_chk("w32.borr",  32, 1'b1, 32'h1234_5678, 32'h1234_5679, 32'hFFFF_FFFF, 1'b0, 1'b0);
    op_chk("w32.novf",  32, 1'b1, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Exhaustive 2-bit against the reference
    for (int s = 0; s < 2; s++)
      for (int ia = 0; ia < 4; ia++)
        for (int ib = 0; ib < 4; ib++) begin
          model(2, s[0], 32'(ia), 32'(ib), es, ec, eo);
          op_chk($sformatf("w2.%0d.%0d.%0d", s, ia, ib), 2, s[0], 32'(ia), 32'(ib), es, ec, eo);
        end

    // Random 32-bit against the reference
    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      rb = $urandom;
      sb = $urandom_range(0, 1) != 0;
      model(32, sb, ra, rb, es, ec, eo);
      op_chk($sformatf("w32.r%0d", i), 32, sb, ra, rb, es, ec, eo);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
